parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
Sequences one shared barrier gate between the normal and handicapped lots. Captures entry/exit sensor events from both lots and arbitrates them, one at a time. Opens the gate for a timed window and issues single-cycle inc/dec strobes to the lot counters. Refuses entries to a full lot and exits from an empty lot. Sits between the raw sensor inputs and the normal/handicapped occupancy counters inside the top-level parking system.

Parameters:
OPEN_CYCLES, 8, cycles gate_open is held high per granted event (>=1)
CLOSE_CYCLES, 2, guard cycles with gate closed before the next grant (>=1)
TMR_W, 4, timer width; must hold max(OPEN_CYCLES, CLOSE_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
n_entry  in  1  normal-lot entry sensor, level; event = rising edge
n_exit  in  1  normal-lot exit sensor, level; event = rising edge
h_entry  in  1  handicapped-lot entry sensor, level; event = rising edge
h_exit  in  1  handicapped-lot exit sensor, level; event = rising edge
n_full  in  1  normal lot full, from normal counter
h_full  in  1  handicapped lot full, from handicapped counter
n_empty  in  1  normal lot empty
h_empty  in  1  handicapped lot empty
gate_open  out  1  barrier open command
n_inc, n_dec, h_inc, h_dec  out  1 each  one-cycle counter strobes
deny  out  1  one-cycle pulse when a request is refused
grant_id  out  2  served request: 0 n_entry, 1 n_exit, 2 h_entry, 3 h_exit; valid while busy
busy  out  1  high in OPEN and CLOSE

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; state IDLE; pending[3:0]=0; sensor edge registers=0; rr=0.
  - Reset mid-OPEN drops gate_open immediately and discards all pending requests.
- Edge detect:
  - Registered previous sensor value per input; a rising edge sets pending[i] on the next clk edge.
  - An edge on an already-set pending bit merges; it does not queue a second event.
- Arbitration, evaluated in IDLE when pending != 0:
  - Exits take priority over entries.
  - Within a class, h vs n alternate via an rr bit. rr toggles after every grant or deny in that class; class-shared rr is acceptable.
  - The winner's pending bit clears in the same cycle it is evaluated.
  - Exactly one winner per evaluation.
- Refusal:
  - An entry winner whose lot is full, or an exit winner whose lot is empty, pulses deny for 1 cycle.
  - No strobe, no gate; FSM stays IDLE.
  - The next evaluation occurs the following cycle.
- FSM:
  - IDLE -> OPEN on accepted winner.
  - OPEN: gate_open=1 for exactly OPEN_CYCLES cycles. The matching inc/dec strobe is high only in the first OPEN cycle, i.e. 1 cycle after the winner is evaluated. grant_id is latched.
  - OPEN -> CLOSE after OPEN_CYCLES.
  - CLOSE: gate_open=0 for CLOSE_CYCLES cycles.
  - CLOSE -> IDLE.
  - busy=1 in OPEN and CLOSE.
- Concurrency:
  - Sensor edges arriving during OPEN/CLOSE are latched into pending and served after return to IDLE.
  - Simultaneous edges on all four inputs are served in order h_exit/n_exit first (per rr), then entries.
- Latency:
  - Sensor rise to pending: 1 cycle.
  - Pending to gate_open: 1 cycle (IDLE evaluation), plus gate_open registered.
  - Total sensor rise to gate_open high: 2 cycles when idle.
- Full/empty inputs are sampled at evaluation only; changes during OPEN do not abort the cycle.
- Timer counts down from OPEN_CYCLES-1 / CLOSE_CYCLES-1; no wrap beyond 0.

Optional Feature:
- Macro PARK_ARB_STATS_EN.
- When defined:
  - Adds output deny_cnt [7:0], incremented on every deny pulse.
  - Saturates at 255; cleared only by reset.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Idle, n_full=0, n_entry rises at cycle 10 -> gate_open high cycles 12..19 (OPEN_CYCLES=8); n_inc high only at cycle 12; grant_id=0; busy low again at cycle 22.
- h_full=1, h_entry rises -> deny pulse 1 cycle at evaluation; no gate_open, no h_inc; busy stays 0.
- All four sensors rise in the same cycle, nothing full or empty -> four grants served in exit-then-entry order (h_exit, n_exit, h_entry, n_entry with rr=0); exactly one strobe per grant; gate closes for 2 cycles between each.
- n_exit rises twice during an h_exit OPEN window -> a single n_exit grant follows; n_dec pulses once.
- reset asserted low mid-OPEN (cycle 4 of 8) with n_entry pending -> gate_open=0 immediately; after release no grant occurs until a new edge arrives.
- PARK_ARB_STATS_EN defined, 300 refused entries with n_full=1 -> deny_cnt holds at 255.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - shared barrier gate arbiter for normal and handicapped lots
// Optional PARK_ARB_STATS_EN adds a saturating deny_cnt output.
module parking_gate_arbiter #(
  parameter int OPEN_CYCLES  = 8,
  parameter int CLOSE_CYCLES = 2,
  parameter int TMR_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       n_entry,
  input  logic       n_exit,
  input  logic       h_entry,
  input  logic       h_exit,
  input  logic       n_full,
  input  logic       h_full,
  input  logic       n_empty,
  input  logic       h_empty,
  output logic       gate_open,
  output logic       n_inc,
  output logic       n_dec,
  output logic       h_inc,
  output logic       h_dec,
  output logic       deny,
  output logic [1:0] grant_id,
`ifdef PARK_ARB_STATS_EN
  output logic [7:0] deny_cnt,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       sens, sens_q, pending, clr;
  logic [3:0]       strobe_q, strobe_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             rr, rr_nxt;
  logic [1:0]       gid_nxt, win_id;
  logic             win_valid, blocked;

  // Request index doubles as strobe index: 0 n_entry/n_inc, 1 n_exit/n_dec, 2 h_entry/h_inc, 3 h_exit/h_dec.
  assign sens = {h_exit, h_entry, n_exit, n_entry};

  always_comb begin
    win_valid = 1'b0;
    win_id    = 2'd0;
    if (pending[1] || pending[3]) begin
      win_valid = 1'b1;
      win_id    = (pending[3] && (!rr || !pending[1])) ? 2'd3 : 2'd1;
    end else if (pending[0] || pending[2]) begin
      win_valid = 1'b1;
      win_id    = (pending[2] && (!rr || !pending[0])) ? 2'd2 : 2'd0;
    end
    case (win_id)
      2'd0:    blocked = n_full;
      2'd1:    blocked = n_empty;
      2'd2:    blocked = h_full;
      default: blocked = h_empty;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    rr_nxt     = rr;
    clr        = 4'd0;
    strobe_nxt = 4'd0;
    gid_nxt    = grant_id;
    deny       = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          clr[win_id] = 1'b1;
          rr_nxt      = ~rr;
          if (blocked) begin
            deny = 1'b1;
          end else begin
            state_nxt          = OPEN;
            tmr_nxt            = TMR_W'(OPEN_CYCLES - 1);
            gid_nxt            = win_id;
            strobe_nxt[win_id] = 1'b1;
          end
        end
      end
      OPEN: begin
        if (tmr == '0) begin
          state_nxt = CLOSE;
          tmr_nxt   = TMR_W'(CLOSE_CYCLES - 1);
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      CLOSE: begin
        if (tmr == '0) state_nxt = IDLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      rr       <= 1'b0;
      sens_q   <= 4'd0;
      pending  <= 4'd0;
      strobe_q <= 4'd0;
      grant_id <= 2'd0;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      rr       <= rr_nxt;
      sens_q   <= sens;
      // A fresh edge on the bit being served survives so it is not lost.
      pending  <= (pending & ~clr) | (sens & ~sens_q);
      strobe_q <= strobe_nxt;
      grant_id <= gid_nxt;
    end
  end

`ifdef PARK_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      deny_cnt <= 8'd0;
    else if (deny && deny_cnt != 8'hFF) deny_cnt <= deny_cnt + 8'd1;
  end
`endif

  assign gate_open = (state == OPEN);
  assign busy      = (state != IDLE);
  assign n_inc     = strobe_q[0];
  assign n_dec     = strobe_q[1];
  assign h_inc     = strobe_q[2];
  assign h_dec     = strobe_q[3];

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed self-checking bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       n_entry, n_exit, h_entry, h_exit;
  logic       n_full, h_full, n_empty, h_empty;
  logic       gate_open, n_inc, n_dec, h_inc, h_dec, deny, busy;
  logic [1:0] grant_id;
`ifdef PARK_ARB_STATS_EN
  logic [7:0] deny_cnt;
`endif
  int         n_cmp = 0;
  int         n_err = 0;

  parking_gate_arbiter dut (
    .clk(clk), .reset(rst_n),
    .n_entry(n_entry), .n_exit(n_exit), .h_entry(h_entry), .h_exit(h_exit),
    .n_full(n_full), .h_full(h_full), .n_empty(n_empty), .h_empty(h_empty),
    .gate_open(gate_open), .n_inc(n_inc), .n_dec(n_dec), .h_inc(h_inc), .h_dec(h_dec),
    .deny(deny), .grant_id(grant_id),
`ifdef PARK_ARB_STATS_EN
    .deny_cnt(deny_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {4'd0, h_dec, h_inc, n_dec, n_inc};
  endfunction

  // Entered in the evaluation cycle; returns in the next evaluation cycle.
  task automatic serve(input logic [1:0] id, input string tag);
    logic [7:0] exp_s;
    exp_s = 8'd1 << id;
    tick();
    chk({tag, "_gate_first"}, {7'd0, gate_open}, 8'd1);
    chk({tag, "_grant_id"}, {6'd0, grant_id}, {6'd0, id});
    chk({tag, "_strobe_first"}, strobes(), exp_s);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk({tag, "_gate_open"}, {7'd0, gate_open}, 8'd1);
      chk({tag, "_strobe_quiet"}, strobes(), 8'd0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_close_gate"}, {7'd0, gate_open}, 8'd0);
      chk({tag, "_close_busy"}, {7'd0, busy}, 8'd1);
    end
    tick();
    chk({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    {n_entry, n_exit, h_entry, h_exit} = 4'd0;
    {n_full, h_full, n_empty, h_empty} = 4'd0;
    tick();
    tick();
    chk("rst_gate", {7'd0, gate_open}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_strobes", strobes(), 8'd0);
    chk("rst_deny", {7'd0, deny}, 8'd0);
    chk("rst_grant_id", {6'd0, grant_id}, 8'd0);
    rst_n = 1'b1;
    tick();

    // Single normal entry: pending next edge, evaluation, then OPEN.
    n_entry = 1'b1;
    tick();
    chk("s1_eval_gate", {7'd0, gate_open}, 8'd0);
    chk("s1_eval_busy", {7'd0, busy}, 8'd0);
    serve(2'd0, "s1");
    n_entry = 1'b0;
    tick();

    // Refusals: full entry, empty exit, full entry (rr ends at 0).
    h_full = 1'b1; h_entry = 1'b1;
    tick();
    chk("s2_h_full_deny", {7'd0, deny}, 8'd1);
    chk("s2_h_full_busy", {7'd0, busy}, 8'd0);
    h_entry = 1'b0;
    tick();
    chk("s2_deny_one_cycle", {7'd0, deny}, 8'd0);
    chk("s2_no_gate", {7'd0, gate_open}, 8'd0);
    chk("s2_no_strobe", strobes(), 8'd0);
    h_full = 1'b0;
    n_empty = 1'b1; n_exit = 1'b1;
    tick();
    chk("s2_n_empty_deny", {7'd0, deny}, 8'd1);
    n_exit = 1'b0;
    tick();
    chk("s2_n_empty_nostrobe", strobes(), 8'd0);
    chk("s2_n_empty_busy", {7'd0, busy}, 8'd0);
    n_empty = 1'b0;
    n_full = 1'b1; n_entry = 1'b1;
    tick();
    chk("s2_n_full_deny", {7'd0, deny}, 8'd1);
    n_entry = 1'b0;
    tick();
    chk("s2_n_full_busy", {7'd0, busy}, 8'd0);
    n_full = 1'b0;
    tick();

    // All four at once: h_exit, n_exit, h_entry, n_entry.
    {n_entry, n_exit, h_entry, h_exit} = 4'b1111;
    tick();
    chk("s3_eval_busy", {7'd0, busy}, 8'd0);
    serve(2'd3, "s3_hx");
    serve(2'd1, "s3_nx");
    serve(2'd2, "s3_he");
    serve(2'd0, "s3_ne");
    chk("s3_drained_busy", {7'd0, busy}, 8'd0);
    {n_entry, n_exit, h_entry, h_exit} = 4'b0000;
    tick();

    // Two n_exit edges during an h_exit OPEN window merge into one grant.
    h_exit = 1'b1;
    tick();
    tick();
    chk("s4_hx_gate", {7'd0, gate_open}, 8'd1);
    chk("s4_hx_strobe", strobes(), 8'b1000);
    n_exit = 1'b1;
    tick();
    n_exit = 1'b0;
    tick();
    n_exit = 1'b1;
    tick();
    n_exit = 1'b0; h_exit = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("s4_hx_last_open", {7'd0, gate_open}, 8'd1);
    tick();
    tick();
    chk("s4_close_gate", {7'd0, gate_open}, 8'd0);
    tick();
    chk("s4_eval_busy", {7'd0, busy}, 8'd0);
    serve(2'd1, "s4_nx");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_no_second_grant", {7'd0, busy}, 8'd0);
    end

    // Reset in the 4th OPEN cycle with n_entry pending.
    h_entry = 1'b1;
    tick();
    h_entry = 1'b0;
    tick();
    n_entry = 1'b1;
    tick();
    n_entry = 1'b0;
    tick();
    tick();
    chk("s5_open4_gate", {7'd0, gate_open}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("s5_async_gate", {7'd0, gate_open}, 8'd0);
    chk("s5_async_busy", {7'd0, busy}, 8'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_pending_discarded", {7'd0, busy}, 8'd0);
    end
    n_entry = 1'b1;
    tick();
    serve(2'd0, "s5_new");
    n_entry = 1'b0;
    tick();

`ifdef PARK_ARB_STATS_EN
    chk("s6_cnt_after_reset", deny_cnt, 8'd0);
    n_full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      n_entry = 1'b1;
      tick();
      n_entry = 1'b0;
      tick();
      if (i == 9) chk("s6_cnt_10", deny_cnt, 8'd10);
    end
    chk("s6_cnt_saturated", deny_cnt, 8'd255);
    n_full = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
